// File: rtl/seq_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_muldiv_ctrl_pkg : FSM state and op-code encodings for the mul/div unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_muldiv_ctrl_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PREP = 3'd1;
   localparam logic [2:0] ST_ITER = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_muldiv_ctrl_arith.sv
// ---------------------------------------------------------------------------
// simplified_signed_adder / complimenter_2 : shared add/sub stage and negator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module simplified_signed_adder #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             add_sub,
   output logic [WIDTH-1:0] sum
);

   assign sum = add_sub ? (a - b) : (a + b);

endmodule

module complimenter_2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value_in,
   output logic [WIDTH-1:0] value_out
);

   assign value_out = ~value_in + WIDTH'(1);

endmodule

`default_nettype wire

// File: rtl/seq_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// seq_muldiv_ctrl : iterative signed/unsigned multiply and restoring divide
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_muldiv_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);
   import seq_muldiv_ctrl_pkg::*;

   localparam int CW = $clog2(WIDTH);

   logic [2:0]       state;
   logic             op_q, sgn_q, dz_wait, neg_q, neg_rem;
   logic [WIDTH-1:0] a_q, b_q, opnd, acc, lo;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0]   a_neg, b_neg, a_mag, b_mag, quot_neg, rem_neg;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH:0]     add_a, add_b, sum, mul_step;

   complimenter_2 #(.WIDTH(WIDTH)) u_neg_a (.value_in(a_q), .value_out(a_neg));
   complimenter_2 #(.WIDTH(WIDTH)) u_neg_b (.value_in(b_q), .value_out(b_neg));
   complimenter_2 #(.WIDTH(WIDTH)) u_neg_quot (.value_in(lo), .value_out(quot_neg));
   complimenter_2 #(.WIDTH(WIDTH)) u_neg_rem (.value_in(acc), .value_out(rem_neg));
   complimenter_2 #(.WIDTH(2*WIDTH)) u_neg_prod (.value_in({acc, lo}), .value_out(prod_neg));

   assign a_mag = (sgn_q && a_q[WIDTH-1]) ? a_neg : a_q;
   assign b_mag = (sgn_q && b_q[WIDTH-1]) ? b_neg : b_q;

   // Divide feeds the shifted partial remainder; multiply feeds the accumulator.
   assign add_a = (op_q == OP_DIV) ? {acc, lo[WIDTH-1]} : {1'b0, acc};
   assign add_b = {1'b0, opnd};

   simplified_signed_adder #(.WIDTH(WIDTH+1)) u_step (
      .a       (add_a),
      .b       (add_b),
      .add_sub (op_q),
      .sum     (sum)
   );

   assign mul_step = lo[0] ? sum : add_a;

   assign busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_q        <= OP_MUL;
         sgn_q       <= 1'b0;
         dz_wait     <= 1'b0;
         neg_q       <= 1'b0;
         neg_rem     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         opnd        <= '0;
         acc         <= '0;
         lo          <= '0;
         cnt         <= '0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  sgn_q   <= sgn;
                  a_q     <= a;
                  b_q     <= b;
                  dz_wait <= 1'b0;
                  state   <= ST_PREP;
               end
            end
            ST_PREP: begin
               // A zero divisor holds PREP one extra cycle before reporting.
               if (op_q == OP_DIV && b_q == '0) begin
                  if (!dz_wait) begin
                     dz_wait <= 1'b1;
                  end else begin
                     result_lo   <= '1;
                     result_hi   <= a_q;
                     div_by_zero <= 1'b1;
                     state       <= ST_DONE;
                  end
               end else begin
                  div_by_zero <= 1'b0;
                  acc         <= '0;
                  cnt         <= '0;
                  neg_q       <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  neg_rem     <= sgn_q & a_q[WIDTH-1];
                  lo          <= (op_q == OP_DIV) ? a_mag : b_mag;
                  opnd        <= (op_q == OP_DIV) ? b_mag : a_mag;
                  state       <= ST_ITER;
               end
            end
            ST_ITER: begin
               if (op_q == OP_DIV) begin
                  acc <= sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
                  lo  <= {lo[WIDTH-2:0], ~sum[WIDTH]};
               end else begin
                  acc <= mul_step[WIDTH:1];
                  lo  <= {mul_step[0], lo[WIDTH-1:1]};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (op_q == OP_DIV) begin
                  result_lo <= neg_q ? quot_neg : lo;
                  result_hi <= neg_rem ? rem_neg : acc;
               end else begin
                  {result_hi, result_lo} <= neg_q ? prod_neg : {acc, lo};
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
